// File: rtl/crc32_frame_arb.sv
// Frame arbiter sharing one byte-serial reflected CRC-32 engine between two requesters.
// Optional residue check on the result is built when CRC32_CHECK_EN is defined.
//
// state | meaning
// IDLE  | no owner; arbitrate between requesters, load CRC seed on grant
// RUN   | owner streams bytes, CRC advances per handshake
// DONE  | result presented, held until consumed
module crc32_frame_arb #(
  parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [31:0] res_crc,
  output logic        res_id,
  input  logic        res_ready,
  output logic        busy
`ifdef CRC32_CHECK_EN
  ,
  output logic        res_ok
`endif
);

  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic        owner_q, owner_d;
  logic        last_id_q, last_id_d;
  logic [31:0] res_crc_q, res_crc_d;
  logic        res_id_q, res_id_d;
  logic        ready0_q, ready0_d;
  logic        ready1_q, ready1_d;
`ifdef CRC32_CHECK_EN
  logic        res_ok_q, res_ok_d;
`endif

  logic        own_valid;
  logic        own_ready;
  logic        own_last;
  logic [7:0]  own_data;
  logic        grant;
  logic [31:0] crc_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'b0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign own_valid = owner_q ? req1_valid : req0_valid;
  assign own_ready = owner_q ? ready1_q   : ready0_q;
  assign own_last  = owner_q ? req1_last  : req0_last;
  assign own_data  = owner_q ? req1_data  : req0_data;
  assign crc_next  = crc_byte(crc_q, own_data);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    owner_d   = owner_q;
    last_id_d = last_id_q;
    res_crc_d = res_crc_q;
    res_id_d  = res_id_q;
    ready0_d  = ready0_q;
    ready1_d  = ready1_q;
`ifdef CRC32_CHECK_EN
    res_ok_d  = res_ok_q;
`endif
    // On a tie the requester not served last wins.
    grant = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d  = grant;
          crc_d    = INIT;
          ready0_d = ~grant;
          ready1_d = grant;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (own_valid && own_ready) begin
          crc_d = crc_next;
          if (own_last) begin
            res_crc_d = crc_next ^ XOROUT;
            res_id_d  = owner_q;
            last_id_d = owner_q;
            ready0_d  = 1'b0;
            ready1_d  = 1'b0;
`ifdef CRC32_CHECK_EN
            res_ok_d  = (crc_next == RESIDUE);
`endif
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      owner_q   <= 1'b0;
      last_id_q <= 1'b1;
      res_crc_q <= 32'h0;
      res_id_q  <= 1'b0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
`ifdef CRC32_CHECK_EN
      res_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      owner_q   <= owner_d;
      last_id_q <= last_id_d;
      res_crc_q <= res_crc_d;
      res_id_q  <= res_id_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
`ifdef CRC32_CHECK_EN
      res_ok_q  <= res_ok_d;
`endif
    end
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign res_valid  = (state_q == DONE);
  assign res_crc    = res_crc_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != IDLE);
`ifdef CRC32_CHECK_EN
  assign res_ok     = res_ok_q;
`endif

endmodule

// File: tb/tb_crc32_frame_arb.sv
// Directed bench for crc32_frame_arb: arbitration, stalls, result hold, reset mid-frame.
// Residue checks are included when CRC32_CHECK_EN is defined.
module tb_crc32_frame_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  req0_data, req1_data;
  logic        res_valid, res_id, res_ready, busy;
  logic [31:0] res_crc;
`ifdef CRC32_CHECK_EN
  logic        res_ok;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  crc32_frame_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_crc(res_crc), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
`ifdef CRC32_CHECK_EN
    , .res_ok(res_ok)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Streams bytes from one requester at negedges; returns cycles spent (incl. grant cycle).
  task automatic send(input bit id, input logic [7:0] q[$], input bit do_last,
                      input int gap_at, input int gap_len, output int cyc);
    int i = 0;
    int gaps = 0;
    logic r, v;
    cyc = 0;
    while (i < q.size() && cyc < 500) begin
      v = !(i == gap_at && gaps < gap_len);
      if (id) begin
        req1_valid = v; req1_data = q[i]; req1_last = do_last && (i == q.size() - 1);
        r = req1_ready;
      end else begin
        req0_valid = v; req0_data = q[i]; req0_last = do_last && (i == q.size() - 1);
        r = req0_ready;
      end
      if (!v) begin
        gaps++;
        check("other_ready_in_gap", {31'b0, id ? req0_ready : req1_ready}, 32'h0);
      end
      @(negedge clk);
      cyc++;
      if (r && v) i++;
    end
    if (id) begin req1_valid = 1'b0; req1_last = 1'b0; end
    else    begin req0_valid = 1'b0; req0_last = 1'b0; end
    check("send_timeout", {31'b0, cyc >= 500}, 32'h0);
  endtask

  logic [7:0] s123[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial begin
    int cyc;
    int w;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    repeat (2) @(negedge clk);

    check("rst_ready0", {31'b0, req0_ready}, 32'h0);
    check("rst_ready1", {31'b0, req1_ready}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_res_valid", {31'b0, res_valid}, 32'h0);
    check("rst_res_crc", res_crc, 32'h0);
    check("rst_res_id", {31'b0, res_id}, 32'h0);
`ifdef CRC32_CHECK_EN
    check("rst_res_ok", {31'b0, res_ok}, 32'h0);
`endif
    rst_n = 1'b1;

    // Both requesters continuously offer single-byte 0x00 frames: strict alternation from req0.
    req0_valid = 1; req0_data = 8'h00; req0_last = 1;
    req1_valid = 1; req1_data = 8'h00; req1_last = 1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      @(negedge clk);
      while (!res_valid && w < 20) begin @(negedge clk); w++; end
      check("alt_timeout", {31'b0, w >= 20}, 32'h0);
      check("alt_res_id", {31'b0, res_id}, (k % 2 == 0) ? 32'h0 : 32'h1);
      check("alt_res_crc", res_crc, 32'hD202EF8D);
    end
    req0_valid = 0; req0_last = 0;
    req1_valid = 0; req1_last = 0;
    repeat (2) @(negedge clk);

    // "123456789" gap-free; result 10 cycles after the IDLE grant cycle; then held 4 cycles.
    res_ready = 1'b0;
    send(1'b0, s123, 1'b1, -1, 0, cyc);
    check("lat_cycles", cyc, 32'd10);
    check("lat_res_valid", {31'b0, res_valid}, 32'h1);
    check("lat_res_crc", res_crc, 32'hCBF43926);
    check("lat_res_id", {31'b0, res_id}, 32'h0);
    req1_valid = 1; req1_data = 8'h00; req1_last = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_res_valid", {31'b0, res_valid}, 32'h1);
      check("hold_res_crc", res_crc, 32'hCBF43926);
      check("hold_res_id", {31'b0, res_id}, 32'h0);
      check("hold_ready1", {31'b0, req1_ready}, 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("ret_idle_busy", {31'b0, busy}, 32'h0);
    check("ret_idle_ready1", {31'b0, req1_ready}, 32'h0);
    @(negedge clk);
    check("ret_grant_ready1", {31'b0, req1_ready}, 32'h1);
    @(negedge clk);
    check("single_res_valid", {31'b0, res_valid}, 32'h1);
    check("single_res_crc", res_crc, 32'hD202EF8D);
    check("single_res_id", {31'b0, res_id}, 32'h1);
    req1_valid = 0; req1_last = 0;
    repeat (2) @(negedge clk);

    // Owner stalls 5 cycles mid-frame while req1 waits; CRC must match the gap-free value.
    req1_valid = 1; req1_data = 8'h00; req1_last = 1;
    send(1'b0, s123, 1'b1, 4, 5, cyc);
    req1_valid = 0; req1_last = 0;
    check("stall_cycles", cyc, 32'd15);
    check("stall_res_valid", {31'b0, res_valid}, 32'h1);
    check("stall_res_crc", res_crc, 32'hCBF43926);
    check("stall_res_id", {31'b0, res_id}, 32'h0);
    repeat (3) @(negedge clk);
    check("stall_no_regrant", {31'b0, busy}, 32'h0);

    // Reset after 4 bytes: frame discarded.
    send(1'b0, s123[0:3], 1'b0, -1, 0, cyc);
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready0", {31'b0, req0_ready}, 32'h0);
    check("mid_rst_ready1", {31'b0, req1_ready}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_result", {31'b0, res_valid}, 32'h0);
    end
    send(1'b0, s123, 1'b1, -1, 0, cyc);
    check("post_rst_res_valid", {31'b0, res_valid}, 32'h1);
    check("post_rst_res_crc", res_crc, 32'hCBF43926);
    @(negedge clk);

`ifdef CRC32_CHECK_EN
    begin
      logic [7:0] good[$];
      logic [7:0] bad[$];
      good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
      bad  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCA};
      send(1'b1, good, 1'b1, -1, 0, cyc);
      check("good_res_ok", {31'b0, res_ok}, 32'h1);
      check("good_res_crc", res_crc, 32'h2144DF1C);
      check("good_res_id", {31'b0, res_id}, 32'h1);
      @(negedge clk);
      send(1'b0, bad, 1'b1, -1, 0, cyc);
      check("bad_res_ok", {31'b0, res_ok}, 32'h0);
      @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
